// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative RV32M multiply/divide engine. A single shared shift/add-subtract
//   datapath is sequenced by an IDLE -> ITER -> FIX -> DONE state machine.
//   Multiplies run radix-2 shift-add on a 2*XLEN accumulator, divides run
//   restoring shift-subtract. Operands are converted to magnitudes on
//   acceptance and the result sign is applied once in FIX.
//
// Ports
//   clk     in   1     rising-edge clock
//   reset   in   1     asynchronous active-high reset
//   start   in   1     request a new operation (accepted only in IDLE)
//   funct3  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,
//                      100 DIV,101 DIVU,110 REM,111 REMU
//   op_a    in   XLEN  rs1 (multiplicand / dividend)
//   op_b    in   XLEN  rs2 (multiplier / divisor)
//   flush   in   1     abort the operation in flight
//   busy    out  1     state != IDLE (pipeline stall)
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  final value, held until the next accepted start
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's-complement negation helpers used for operand magnitudes and for
  // the final sign fix-up.
  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

  state_t              r_state;
  logic [2:0]          r_funct3;
  logic                r_sign_a;
  logic                r_sign_b;
  // Multiply: multiplicand. Divide: divisor.
  logic [XLEN-1:0]     r_opnd;
  // Multiply: {product_hi, multiplier shifting out}. Divide: low half holds
  // the dividend shifting out and the quotient shifting in.
  logic [2*XLEN-1:0]   r_acc;
  // Partial remainder; the extra bit keeps the shifted value before compare.
  logic [XLEN:0]       r_rem;
  logic [CNT_W-1:0]    r_count;
  logic [XLEN-1:0]     r_result;

  // ---- acceptance decode (combinational on the request inputs) ----
  logic            w_is_div;
  logic            w_signed_a;
  logic            w_signed_b;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic [XLEN-1:0] w_fast_result;

  assign w_is_div   = funct3[2];
  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
  assign w_signed_a = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]);
  assign w_signed_b = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
  assign w_sign_a   = w_signed_a & op_a[XLEN-1];
  assign w_sign_b   = w_signed_b & op_b[XLEN-1];
  assign w_abs_a    = w_sign_a ? f_neg(op_a) : op_a;
  assign w_abs_b    = w_sign_b ? f_neg(op_b) : op_b;

  assign w_div_zero = w_is_div & (op_b == '0);
  assign w_div_ovf  = funct3[2] & ~funct3[0]
                    & (op_a == {1'b1, {(XLEN-1){1'b0}}})
                    & (op_b == {XLEN{1'b1}});

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  // funct3[1] distinguishes REM/REMU from DIV/DIVU. On overflow op_a is
  // exactly the most negative value, which is the DIV answer.
  always_comb begin
    w_fast_result = '0;
    if (w_div_zero) begin
      w_fast_result = funct3[1] ? op_a : {XLEN{1'b1}};
    end else if (w_div_ovf) begin
      w_fast_result = funct3[1] ? '0 : op_a;
    end
  end

  // ---- iteration step (one bit per cycle) ----
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN+1:0]   w_div_shift;
  logic [XLEN+1:0]   w_div_diff;
  logic              w_div_ge;

  // Shift-add: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide: bring the next dividend bit into the remainder and
  // keep the difference only when it did not borrow.
  assign w_div_shift = {r_rem, r_acc[XLEN-1]};
  assign w_div_diff  = w_div_shift - {2'b00, r_opnd};
  assign w_div_ge    = ~w_div_diff[XLEN+1];

  // ---- sign fix-up and word selection ----
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_result;

  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? f_neg2(r_acc) : r_acc;
  assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? f_neg(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
  // Remainder takes the sign of the dividend.
  assign w_rem_fix  = r_sign_a ? f_neg(r_rem[XLEN-1:0]) : r_rem[XLEN-1:0];

  always_comb begin
    w_fix_result = '0;
    case (r_funct3)
      3'b000:                 w_fix_result = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_result = w_quo_fix;
      default:                w_fix_result = w_rem_fix;
    endcase
  end

  // ---- sequencer ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_funct3 <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A simultaneous flush suppresses acceptance.
          if (start && !flush) begin
            r_funct3 <= funct3;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_count  <= '0;
            r_rem    <= '0;
            if (w_is_div) begin
              r_opnd <= w_abs_b;
              r_acc  <= {{XLEN{1'b0}}, w_abs_a};
            end else begin
              r_opnd <= w_abs_a;
              r_acc  <= {{XLEN{1'b0}}, w_abs_b};
            end
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_fast_result;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_ITER;
            end
          end
        end

        S_ITER: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_funct3[2]) begin
              r_rem <= w_div_ge ? w_div_diff[XLEN:0] : w_div_shift[XLEN:0];
              r_acc <= {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], w_div_ge};
            end else begin
              r_acc <= w_mul_next;
            end
            // Counter stops at the last step instead of wrapping.
            if (r_count == CNT_LAST) begin
              r_state <= S_FIX;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end

        S_FIX: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_fix_result;
            r_state  <= S_DONE;
          end
        end

        default: begin
          // DONE: the pulse is already committed, flush or not.
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle engine for the RV32M multiply/divide instructions (opcode 0110011, funct7 0x01).
- Sits beside the single-cycle ALU in the execute stage. The datapath raises `start` with operands and funct3, holds the pipeline while `busy` is high, and takes `result` on the `done` pulse.
- Uses one shared shift/add-subtract datapath, sequenced by an FSM.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; accepted only in IDLE.
- funct3  input  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value (multiplicand/dividend).
- op_b  input  XLEN  rs2 value (multiplier/divisor).
- flush  input  1  abort the current operation (branch mispredict/exception).
- busy  output  1  high while state is not IDLE; the pipeline stalls on it.
- done  output  1  one-cycle pulse; `result` is valid in this cycle.
- result  output  XLEN  final value; held until the next accepted start.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. It forces state IDLE, busy=0, done=0, result=0, and clears internal registers and the counter.
- States: IDLE, ITER, FIX, DONE.
- Acceptance: start=1 in IDLE latches funct3, operand signs and absolute values (signedness per funct3), sets count=0, then:
  - normal case: go to ITER;
  - special division cases (below): go directly to DONE.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MUL, MULHU, DIVU, REMU: both operands unsigned magnitude. MUL low word is sign-agnostic.
- ITER, multiply: one radix-2 shift-add step per cycle on a 2*XLEN accumulator.
- ITER, divide: one restoring shift-subtract step per cycle, producing one quotient bit and updating the partial remainder.
- ITER exit: count increments each cycle; leaves ITER after exactly XLEN cycles (count==XLEN-1 → FIX).
- FIX: applies two's-complement negation where the result sign is negative:
  - product: sign_a XOR sign_b (for the sign-treated operands);
  - quotient: sign_a XOR sign_b;
  - remainder: sign of dividend.
  - It then registers the selected word into `result`:
    - MUL: product[XLEN-1:0];
    - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN];
    - DIV/DIVU: quotient;
    - REM/REMU: remainder.
  - FIX → DONE.
- DONE: done=1 for exactly this cycle, then → IDLE.
- Latency: start in cycle T gives done in cycle T+XLEN+2 (T+34 at XLEN=32). Fast path: done in T+1.
- Special cases (fast path, result loaded on acceptance):
  - Divide by zero (op_b==0):
    - DIV/DIVU → all-ones;
    - REM/REMU → op_a.
  - Signed overflow (DIV/REM, op_a = 0x8000_0000, op_b = 0xFFFF_FFFF):
    - DIV → 0x8000_0000;
    - REM → 0.
- busy: 1 in ITER, FIX and DONE; 0 in IDLE. Combinationally it is (state != IDLE), so busy is 0 in the start cycle itself; the datapath stalls from T+1.
- start while busy: ignored; no queueing.
- flush: in any non-IDLE state, synchronously returns to IDLE next cycle.
  - No done pulse; result keeps its previous value.
  - flush and start together in IDLE: flush wins, start is not accepted.
  - flush in the DONE cycle: done is still 1 in that cycle (already committed).
- reset mid-operation: immediate abort to reset values; no done.
- Widths: internal accumulator 2*XLEN. The divider remainder register is XLEN+1 to hold the borrow bit. The counter is $clog2(XLEN) bits and never wraps past XLEN-1.

Test Plan:
- MUL/MULHU: op_a=0xFFFF_FFFF, op_b=0x0000_0002, start at T.
  - busy=1 from T+1; done only at T+34.
  - MUL → 0xFFFF_FFFE; MULHU → 0x0000_0001.
- Signed high: MULH, op_a=0xFFFF_FFFF(-1), op_b=0x0000_0003 → 0xFFFF_FFFF.
  - MULHSU with the same operands → 0xFFFF_FFFF.
- Divide signs: DIV op_a=-7 (0xFFFF_FFF9), op_b=2 → 0xFFFF_FFFD (-3).
  - REM with the same operands → 0xFFFF_FFFF (-1).
  - DIVU op_a=7, op_b=2 → 3.
- Special cases:
  - DIVU op_b=0 → 0xFFFF_FFFF, done at T+1.
  - REM op_a=5, op_b=0 → 5.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM of the same → 0.
- Abort:
  - flush at T+10 → busy=0 at T+11, no done pulse, result unchanged.
  - A start pulsed at T+5 during ITER is ignored (result matches the first op only).
- Reset: assert reset asynchronously mid-ITER → busy, done, result go 0 immediately.
  - After release, a new MUL 3×4 → 12 at T+34.
